fp_acc: RTL and testbench
=========================

FP_ACC -- requirements
Module: fp_acc

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the term counter out_count.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_p carries a product term this cycle.
REQ-005 SHALL have port in_p  input  32  IEEE-754 single-precision product, the registered fp_mult output.
REQ-006 SHALL have port in_last  input  1  qualified by in_valid; marks the final term of a dot product.
REQ-007 SHALL have port out_valid  output  1  one-cycle pulse; out_sum and out_count valid.
REQ-008 SHALL have port out_sum  output  32  IEEE-754 single accumulated sum.
REQ-009 SHALL have port out_count  output  CNT_W  number of terms in out_sum.
REQ-010 SHALL have port busy  output  1  high while an accumulation is open (state ACC).

Function
REQ-011 SHALL accept one term per cycle with no backpressure; every cycle with in_valid=1 consumes in_p.
REQ-012 SHALL implement states IDLE (no open sum), ACC (sum open), DONE (result presented).
REQ-013 SHALL, in IDLE or DONE with in_valid=1, load the accumulator with in_p and the count with 1; next state ACC, or DONE if in_last=1.
REQ-014 SHALL, in ACC with in_valid=1, set acc <= acc + in_p and count <= count+1; next state DONE if in_last=1, else stay ACC.
REQ-015 SHALL, in ACC with in_valid=0, hold acc, count and state.
REQ-016 SHALL, in DONE with in_valid=0, return to IDLE.
REQ-017 SHALL ignore in_last when in_valid=0.
REQ-018 SHALL register out_sum/out_count and pulse out_valid on the edge that accepts the in_last term, giving latency 1 cycle from last-term sample to out_valid=1.
REQ-019 SHALL hold out_sum/out_count stable until the next result; only out_valid drops after one cycle.
REQ-020 SHALL perform the add in one cycle: align, add or subtract mantissas, normalize, round toward zero (truncate).
REQ-021 SHALL flush denormal inputs and denormal results to +0.
REQ-022 SHALL produce +0 (0x00000000) on exact cancellation.
REQ-023 SHALL saturate out_count at all-ones rather than wrap.
REQ-024 SHALL support back-to-back dot products: a term in the DONE cycle starts a new sum with no idle cycle.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-accumulation, drive immediately: state IDLE, acc 0, count 0, out_valid 0, out_sum 0x00000000, out_count 0, busy 0.
REQ-026 SHALL discard any partial sum on reset; the first term after rst deasserts starts a new sum.

Configuration
REQ-027 SHALL, with FP_ACC_SPECIAL_EN defined, treat exponent 255 per IEEE: any NaN or Inf+(-Inf) gives 0x7FC00000, Inf propagates signed, and exponent overflow gives signed Inf.
REQ-028 SHALL, without FP_ACC_SPECIAL_EN, treat exponent 255 as an ordinary finite exponent and saturate overflow to signed max finite (0x7F7FFFFF/0xFF7FFFFF).

Verification
REQ-029 SHALL cover: consecutive terms 0x40800000, 0x41800000, 0x42800000, 0x43800000 (last on 4th) -> out_valid one cycle later, out_sum 0x43AA0000 (340.0), out_count 4.
REQ-030 SHALL cover: single term 0x45800000 with in_last -> out_sum 0x45800000, out_count 1; immediate next term 0x40800000 in the DONE cycle starts a fresh sum.
REQ-031 SHALL cover: 0x40800000 then 0xC0800000 (last) -> out_sum 0x00000000; 0x3F800000 + 0x30800000 (last) -> 0x3F800000 (truncation).
REQ-032 SHALL cover: in_valid gaps between terms and in_last with in_valid=0 -> gaps and stray in_last ignored, sum unchanged.
REQ-033 SHALL cover: rst pulse after 2 of 4 terms -> outputs zero immediately; the next 2 terms 0x40000000, 0x40000000 (last) -> 0x40800000, out_count 2.
REQ-034 SHALL cover: 0x7F800000 + 0xFF800000 -> 0x7FC00000 with FP_ACC_SPECIAL_EN; 0x7F000000 + 0x7F000000 -> 0x7F7FFFFF without it.

Source files
------------

// File: rtl/fp_acc.sv
// fp_acc: streaming single-precision accumulator for dot products, truncating adds.
// Define FP_ACC_SPECIAL_EN for IEEE NaN/Inf handling of exponent 255.
module fp_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_p,
  input  logic             in_last,
  output logic             out_valid,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb, e_big, e_sml, d;
    logic [23:0] ma, mb, m_big, m_sml;
    logic s_big, s_sml, swap;
    logic [49:0] sh;
    logic [26:0] big, al;
    logic [27:0] sum;
    logic [4:0] lz;
    logic signed [9:0] e_r;
    logic [22:0] frac;
    logic [31:0] r;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    swap = {eb, mb} > {ea, ma};
    e_big = swap ? eb : ea;
    e_sml = swap ? ea : eb;
    m_big = swap ? mb : ma;
    m_sml = swap ? ma : mb;
    s_big = swap ? b[31] : a[31];
    s_sml = swap ? a[31] : b[31];
    d = e_big - e_sml;
    // Anything shifted past 27 places only contributes its sticky bit.
    sh = {m_sml, 26'd0} >> ((d > 8'd27) ? 8'd27 : d);
    al = {sh[49:24], |sh[23:0]};
    big = {m_big, 3'd0};
    sum = (s_big == s_sml) ? {1'b0, big} + {1'b0, al} : {1'b0, big} - {1'b0, al};
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    e_r = sum[27] ? $signed({2'b0, e_big}) + 10'sd1 : $signed({2'b0, e_big}) - $signed({5'b0, lz});
    frac = sum[27] ? sum[26:4] : 23'((sum[26:0] << lz) >> 3);
    r = (sum == 28'd0 || e_r <= 10'sd0) ? 32'h0 : {s_big, e_r[7:0], frac};
`ifdef FP_ACC_SPECIAL_EN
    if (sum != 28'd0 && e_r >= 10'sd255) r = {s_big, 8'hFF, 23'd0};
    if (eb == 8'hFF) r = b;
    if (ea == 8'hFF) r = a;
    if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0) ||
        (ea == 8'hFF && eb == 8'hFF && a[31] != b[31])) r = 32'h7FC00000;
`else
    if (sum != 28'd0 && e_r >= 10'sd255) r = {s_big, 8'hFE, 23'h7FFFFF};
`endif
    return r;
  endfunction
  state_t state_q, state_d;
  logic [31:0] acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic ov_q, ov_d;
  always_comb begin
    state_d = in_valid ? (in_last ? DONE : ACC) : (state_q == DONE ? IDLE : state_q);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_valid && state_q != ACC) begin
      acc_d = (in_p[30:23] == 8'd0 && in_p[22:0] != 23'd0) ? 32'h0 : in_p;
      cnt_d = CNT_W'(1);
    end else if (in_valid) begin
      acc_d = fp_add(acc_q, in_p);
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    end
    ov_d = in_valid & in_last;
    sum_d = ov_d ? acc_d : sum_q;
    ocnt_d = ov_d ? cnt_d : ocnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= 32'h0;
      cnt_q <= '0;
      sum_q <= 32'h0;
      ocnt_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      ocnt_q <= ocnt_d;
      ov_q <= ov_d;
    end
  end
  assign out_valid = ov_q;
  assign out_sum = sum_q;
  assign out_count = ocnt_q;
  assign busy = (state_q == ACC);
endmodule

// File: tb/tb_fp_acc.sv
// tb_fp_acc: random and directed checks of fp_acc against an exact-arithmetic reference.
// Honours FP_ACC_SPECIAL_EN the same way the design does.
module tb_fp_acc;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_p = 32'h0;
  logic out_valid, busy;
  logic [31:0] out_sum;
  logic [CNT_W-1:0] out_count;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] macc = 0, esum = 0;
  int mcnt = 0, ecnt = 0;
  logic open = 0, ev = 0;

  fp_acc #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_p(in_p), .in_last(in_last),
    .out_valid(out_valid), .out_sum(out_sum), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Exact value scaled by 2^149: every finite single is an integer in this scale.
  function automatic logic signed [289:0] to_fix(input logic [31:0] f);
    logic signed [289:0] v;
    int e;
    e = int'(f[30:23]);
    if (e == 0) return '0;
    v = 290'({1'b1, f[22:0]});
    v = v << (e - 1);
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] from_fix(input logic signed [289:0] v);
    logic [289:0] mag, t;
    logic s;
    int p, e;
    if (v == 0) return 32'h0;
    s = v[289];
    mag = s ? -v : v;
    p = 0;
    for (int i = 0; i < 290; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e < 1) return 32'h0;
`ifdef FP_ACC_SPECIAL_EN
    if (e >= 255) return {s, 8'hFF, 23'd0};
`else
    if (e >= 255) return {s, 8'hFE, 23'h7FFFFF};
`endif
    t = mag >> (p - 23);
    return {s, 8'(e), t[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_ACC_SPECIAL_EN
    logic an, bn, ai, bi;
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    ai = a[30:23] == 8'hFF && a[22:0] == 0;
    bi = b[30:23] == 8'hFF && b[22:0] == 0;
    if (an || bn || (ai && bi && a[31] != b[31])) return 32'h7FC00000;
    if (ai) return a;
    if (bi) return b;
`endif
    return from_fix(to_fix(a) + to_fix(b));
  endfunction

  task automatic step(input logic v, input logic [31:0] p, input logic l);
    in_valid = v;
    in_p = p;
    in_last = l;
    @(posedge clk);
    #1;
    ev = 0;
    if (v) begin
      if (!open) begin
        macc = (p[30:23] == 0 && p[22:0] != 0) ? 32'h0 : p;
        mcnt = 1;
      end else begin
        macc = ref_add(macc, p);
        mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
      end
      open = !l;
      if (l) begin
        ev = 1;
        esum = macc;
        ecnt = mcnt;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(open));
    chk("out_sum", out_sum, esum);
    chk("out_count", 32'(out_count), 32'(ecnt));
  endtask

  function automatic logic [31:0] rnd_fp();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return $urandom & 32'h807FFFFF;
    if (r == 1) return $urandom;
    return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sum", out_sum, 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step(1, 32'h40800000, 0);
    step(1, 32'h41800000, 0);
    step(1, 32'h42800000, 0);
    step(1, 32'h43800000, 1);
    chk("dot4_sum", out_sum, 32'h43AA0000);
    chk("dot4_count", 32'(out_count), 32'd4);
    step(1, 32'h45800000, 1);
    chk("single_sum", out_sum, 32'h45800000);
    step(1, 32'h40800000, 1);
    chk("b2b_sum", out_sum, 32'h40800000);
    chk("b2b_count", 32'(out_count), 32'd1);
    step(1, 32'h40800000, 0);
    step(1, 32'hC0800000, 1);
    chk("cancel_sum", out_sum, 32'h00000000);
    step(0, 32'h0, 0);
    step(1, 32'h3F800000, 0);
    step(1, 32'h30800000, 1);
    chk("trunc_sum", out_sum, 32'h3F800000);
    step(1, 32'h3F800000, 0);
    step(0, 32'h12345678, 1);
    step(0, 32'h0, 0);
    step(1, 32'h3F800000, 0);
    step(0, 32'h0, 1);
    step(1, 32'h40000000, 1);
    chk("gap_sum", out_sum, 32'h40800000);
    chk("gap_count", 32'(out_count), 32'd3);
    step(1, 32'h3F800000, 0);
    step(1, 32'h3F800000, 0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_sum", out_sum, 32'h0);
    chk("arst_count", 32'(out_count), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    open = 0;
    esum = 0;
    ecnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 32'h40000000, 0);
    step(1, 32'h40000000, 1);
    chk("post_rst_sum", out_sum, 32'h40800000);
    chk("post_rst_count", 32'(out_count), 32'd2);
    for (int i = 0; i < 20; i++) step(1, 32'h3F800000, i == 19);
    chk("sat_count", 32'(out_count), 32'(CMAX));
    chk("sat_sum", out_sum, 32'h41A00000);
    step(1, 32'h00400000, 1);
    chk("denorm_flush", out_sum, 32'h0);
`ifdef FP_ACC_SPECIAL_EN
    step(1, 32'h7F800000, 0);
    step(1, 32'hFF800000, 1);
    chk("inf_nan", out_sum, 32'h7FC00000);
    step(1, 32'h7F000000, 0);
    step(1, 32'h7F000000, 1);
    chk("ovf_inf", out_sum, 32'h7F800000);
`else
    step(1, 32'h7F000000, 0);
    step(1, 32'h7F000000, 1);
    chk("ovf_sat", out_sum, 32'h7F7FFFFF);
    step(1, 32'hFF000000, 0);
    step(1, 32'hFF000000, 1);
    chk("ovf_sat_neg", out_sum, 32'hFF7FFFFF);
`endif
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, rnd_fp(), $urandom_range(0, 4) == 0);
    step(1, 32'h3F800000, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
